// File: rtl/fifo_ext_pkg.sv
// Shared constants and elaboration helpers for the fifo_ext buffer.
package fifo_ext_pkg;

    localparam string SHOWAHEAD_ON  = "ON";
    localparam string SHOWAHEAD_OFF = "OFF";

    function automatic int unsigned depth_of(input int unsigned awidth);
        return 32'd1 << awidth;
    endfunction

    function automatic bit af_lvl_ok(input int unsigned lvl, input int unsigned awidth);
        return (lvl >= 32'd1) && (lvl <= depth_of(awidth));
    endfunction

    function automatic bit ae_lvl_ok(input int unsigned lvl, input int unsigned awidth);
        return lvl <= (depth_of(awidth) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ext_ram.sv
// Simple dual-port synchronous RAM with a registered, enabled read port.
// A read of the address being written in the same cycle returns the new word.
module fifo_ext_ram
    import fifo_ext_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = depth_of(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
        end
    end

endmodule

// File: rtl/fifo_ext.sv
// Single-clock FIFO with fill count, threshold flags and showahead option.
// Optional sticky overflow/underflow flags when FIFO_EXT_ERR_FLAGS_EN is defined.
module fifo_ext
    import fifo_ext_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 4,
    parameter string       SHOWAHEAD = "ON",
    parameter int unsigned AF_LVL    = 12,
    parameter int unsigned AE_LVL    = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AWIDTH:0]   usedw_o
`ifdef FIFO_EXT_ERR_FLAGS_EN
    ,
    input  logic              err_clr_i,
    output logic              ovf_o,
    output logic              udf_o
`endif
);

    localparam int unsigned DEPTH = depth_of(AWIDTH);
    localparam int unsigned UW    = AWIDTH + 1;
    localparam bit          SA_ON = (SHOWAHEAD == SHOWAHEAD_ON);

    if (!af_lvl_ok(AF_LVL, AWIDTH)) begin : g_af_lvl_illegal
        $error("fifo_ext: AF_LVL must be within 1..DEPTH");
    end
    if (!ae_lvl_ok(AE_LVL, AWIDTH)) begin : g_ae_lvl_illegal
        $error("fifo_ext: AE_LVL must be within 0..DEPTH-1");
    end
    if ((SHOWAHEAD != SHOWAHEAD_ON) && (SHOWAHEAD != SHOWAHEAD_OFF)) begin : g_sa_illegal
        $error("fifo_ext: SHOWAHEAD must be \"ON\" or \"OFF\"");
    end

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] rd_addr;
    logic              wr_en;
    logic              rd_en;
    logic              ram_re;
    logic              empty_nxt;
    logic [AWIDTH:0]   usedw_nxt;

    // Showahead looks one word ahead and holds empty for one extra edge after
    // a write into an empty FIFO, so the head word is in the read register first.
    always_comb begin
        wr_en     = wrreq_i & ~full_o;
        rd_en     = rdreq_i & ~empty_o;
        usedw_nxt = usedw_o + UW'(wr_en) - UW'(rd_en);
        rd_addr   = rd_ptr;
        ram_re    = rd_en;
        empty_nxt = (usedw_nxt == '0);
        if (SA_ON) begin
            rd_addr   = rd_ptr + AWIDTH'(rd_en);
            ram_re    = 1'b1;
            empty_nxt = (usedw_nxt == '0) || (usedw_o == '0);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            wr_ptr         <= wr_ptr + AWIDTH'(wr_en);
            rd_ptr         <= rd_ptr + AWIDTH'(rd_en);
            usedw_o        <= usedw_nxt;
            empty_o        <= empty_nxt;
            full_o         <= (usedw_nxt == UW'(DEPTH));
            almost_full_o  <= (usedw_nxt >= UW'(AF_LVL));
            almost_empty_o <= (usedw_nxt <= UW'(AE_LVL));
        end
    end

`ifdef FIFO_EXT_ERR_FLAGS_EN
    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (wrreq_i && full_o) begin
                ovf_o <= 1'b1;
            end else if (err_clr_i) begin
                ovf_o <= 1'b0;
            end
            if (rdreq_i && empty_o) begin
                udf_o <= 1'b1;
            end else if (err_clr_i) begin
                udf_o <= 1'b0;
            end
        end
    end
`endif

    fifo_ext_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr),
        .wdata_i (data_i),
        .re_i    (ram_re),
        .raddr_i (rd_addr),
        .rdata_o (q_o)
    );

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: one showahead-OFF (index 0) and one showahead-ON (index 1)
// instance share stimulus and are checked against a queue-based model.
module tb_fifo_ext;

    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 2;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic       wrreq_i;
    logic       rdreq_i;
    logic [7:0] data_i;

    logic [7:0] q_s     [2];
    logic       empty_s [2];
    logic       full_s  [2];
    logic       af_s    [2];
    logic       ae_s    [2];
    logic [4:0] usedw_s [2];
`ifdef FIFO_EXT_ERR_FLAGS_EN
    logic       err_clr_i;
    logic       ovf_s   [2];
    logic       udf_s   [2];
    bit         exp_ovf [2];
    bit         exp_udf [2];
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic [7:0] exp_q0;
    bit         exp_empty [2];

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         rd;
        int         usedw;
        bit         full;
        bit         af;
        bit         empty_off;
        logic [7:0] q_off;
        bit         on_pre_valid;
        logic [7:0] q_on_pre;
    } vec_t;

    vec_t tbl [34];

    always #5 clk_i = ~clk_i;

    fifo_ext #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD("OFF"), .AF_LVL(12), .AE_LVL(2)) u_off (
        .clk_i(clk_i), .arst_i(arst_i), .wrreq_i(wrreq_i), .data_i(data_i), .rdreq_i(rdreq_i),
        .q_o(q_s[0]), .empty_o(empty_s[0]), .full_o(full_s[0]), .almost_full_o(af_s[0]),
        .almost_empty_o(ae_s[0]), .usedw_o(usedw_s[0])
`ifdef FIFO_EXT_ERR_FLAGS_EN
        , .err_clr_i(err_clr_i), .ovf_o(ovf_s[0]), .udf_o(udf_s[0])
`endif
    );

    fifo_ext #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD("ON"), .AF_LVL(12), .AE_LVL(2)) u_on (
        .clk_i(clk_i), .arst_i(arst_i), .wrreq_i(wrreq_i), .data_i(data_i), .rdreq_i(rdreq_i),
        .q_o(q_s[1]), .empty_o(empty_s[1]), .full_o(full_s[1]), .almost_full_o(af_s[1]),
        .almost_empty_o(ae_s[1]), .usedw_o(usedw_s[1])
`ifdef FIFO_EXT_ERR_FLAGS_EN
        , .err_clr_i(err_clr_i), .ovf_o(ovf_s[1]), .udf_o(udf_s[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msize(input int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] mfront(input int m);
        return (m == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic logic [7:0] mpop(input int m);
        if (m == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    function automatic void mpush(input int m, input logic [7:0] d);
        if (m == 0) mq0.push_back(d);
        else        mq1.push_back(d);
    endfunction

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        exp_q0    = 8'h00;
        exp_empty = '{1'b1, 1'b1};
`ifdef FIFO_EXT_ERR_FLAGS_EN
        exp_ovf = '{1'b0, 1'b0};
        exp_udf = '{1'b0, 1'b0};
`endif
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("usedw[%0d]", m), 32'(usedw_s[m]), 32'(msize(m)));
            chk($sformatf("full[%0d]", m), 32'(full_s[m]), 32'(msize(m) == DEPTH));
            chk($sformatf("almost_full[%0d]", m), 32'(af_s[m]), 32'(msize(m) >= AF_LVL));
            chk($sformatf("almost_empty[%0d]", m), 32'(ae_s[m]), 32'(msize(m) <= AE_LVL));
            chk($sformatf("empty[%0d]", m), 32'(empty_s[m]), 32'(exp_empty[m]));
            if (m == 0) chk("q[0]", 32'(q_s[0]), 32'(exp_q0));
            else if (!exp_empty[1]) chk("q[1]_head", 32'(q_s[1]), 32'(mfront(1)));
`ifdef FIFO_EXT_ERR_FLAGS_EN
            chk($sformatf("ovf[%0d]", m), 32'(ovf_s[m]), 32'(exp_ovf[m]));
            chk($sformatf("udf[%0d]", m), 32'(udf_s[m]), 32'(exp_udf[m]));
`endif
        end
    endtask

    // One clock: drive requests, let the edge pass, advance the model, compare.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit wa [2];
        bit ra [2];
        int pre [2];
        logic [7:0] popped;
        wrreq_i = wr;
        data_i  = d;
        rdreq_i = rd;
`ifdef FIFO_EXT_ERR_FLAGS_EN
        err_clr_i = clr;
`else
        if (clr) data_i = d;
`endif
        for (int m = 0; m < 2; m++) begin
            pre[m] = msize(m);
            wa[m]  = wr && (pre[m] != DEPTH);
            ra[m]  = rd && !exp_empty[m];
        end
        @(posedge clk_i);
        #1;
        for (int m = 0; m < 2; m++) begin
`ifdef FIFO_EXT_ERR_FLAGS_EN
            if (wr && pre[m] == DEPTH) exp_ovf[m] = 1'b1;
            else if (clr)              exp_ovf[m] = 1'b0;
            if (rd && exp_empty[m])    exp_udf[m] = 1'b1;
            else if (clr)              exp_udf[m] = 1'b0;
`endif
            if (ra[m]) begin
                popped = mpop(m);
                if (m == 0) exp_q0 = popped;
            end
            if (wa[m]) mpush(m, d);
            if (m == 0) exp_empty[0] = (msize(0) == 0);
            else        exp_empty[1] = (msize(1) == 0) || (pre[1] == 0);
        end
        compare_all();
    endtask

    task automatic pulse_reset();
        #2 arst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("reset_q_on", 32'(q_s[1]), 32'h0);
        #1 arst_i = 1'b0;
    endtask

    initial begin
        int pw;
        int pr;
        arst_i  = 1'b1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        data_i  = 8'h00;
`ifdef FIFO_EXT_ERR_FLAGS_EN
        err_clr_i = 1'b0;
`endif
        model_reset();

        // Fill with 0x00..0x0F, one dropped 0xAA, then drain sixteen plus one extra read.
        for (int i = 0; i < 17; i++) begin
            tbl[i] = '{wr: 1'b1, d: (i < 16) ? 8'(i) : 8'hAA, rd: 1'b0,
                       usedw: (i < 16) ? i + 1 : 16, full: (i >= 15), af: (i + 1 >= 12),
                       empty_off: 1'b0, q_off: 8'h00, on_pre_valid: 1'b0, q_on_pre: 8'h00};
        end
        for (int j = 0; j < 17; j++) begin
            tbl[17 + j] = '{wr: 1'b0, d: 8'h00, rd: 1'b1,
                            usedw: (j < 16) ? 15 - j : 0, full: 1'b0, af: (15 - j >= 12),
                            empty_off: (j >= 15), q_off: (j < 16) ? 8'(j) : 8'h0F,
                            on_pre_valid: (j < 16), q_on_pre: 8'(j)};
        end

        #12;
        compare_all();
        chk("reset_q_on", 32'(q_s[1]), 32'h0);
        #1 arst_i = 1'b0;

        for (int i = 0; i < 34; i++) begin
`ifdef FIFO_EXT_ERR_FLAGS_EN
            if (i == 17) begin
                cycle(1'b0, 8'h00, 1'b0, 1'b1);
                chk("ovf_clr_off", 32'(ovf_s[0]), 32'h0);
                chk("ovf_clr_on", 32'(ovf_s[1]), 32'h0);
                cycle(1'b1, 8'hBB, 1'b0, 1'b1);
                chk("ovf_set_wins_off", 32'(ovf_s[0]), 32'h1);
                chk("ovf_set_wins_on", 32'(ovf_s[1]), 32'h1);
            end
`endif
            if (tbl[i].on_pre_valid) chk("tbl_q_on_pre", 32'(q_s[1]), 32'(tbl[i].q_on_pre));
            cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
            chk($sformatf("tbl%0d_usedw", i), 32'(usedw_s[0]), 32'(tbl[i].usedw));
            chk($sformatf("tbl%0d_full", i), 32'(full_s[0]), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_af", i), 32'(af_s[0]), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_empty", i), 32'(empty_s[0]), 32'(tbl[i].empty_off));
            chk($sformatf("tbl%0d_q", i), 32'(q_s[0]), 32'(tbl[i].q_off));
`ifdef FIFO_EXT_ERR_FLAGS_EN
            if (i == 16) chk("ovf_after_fill", 32'(ovf_s[0]), 32'h1);
            if (i == 33) chk("udf_after_drain", 32'(udf_s[1]), 32'h1);
`endif
        end

        // Showahead latency from empty.
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("sa_on_usedw_e1", 32'(usedw_s[1]), 32'h1);
        chk("sa_on_empty_e1", 32'(empty_s[1]), 32'h1);
        chk("sa_off_empty_e1", 32'(empty_s[0]), 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sa_on_empty_e2", 32'(empty_s[1]), 32'h0);
        chk("sa_on_q_e2", 32'(q_s[1]), 32'h5A);
        chk("sa_off_q_rd", 32'(q_s[0]), 32'h5A);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sa_on_drained", 32'(empty_s[1]), 32'h1);

        // Simultaneous write+read at a count of 7 across pointer wrap.
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
            chk("simul_usedw_off", 32'(usedw_s[0]), 32'h7);
            chk("simul_usedw_on", 32'(usedw_s[1]), 32'h7);
        end
        for (int k = 0; k < 7; k++) begin
            chk("simul_on_head", 32'(q_s[1]), 32'(8'h2D + k));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            chk("simul_off_order", 32'(q_s[0]), 32'(8'h2D + k));
        end

        // Reset in the middle of traffic; requests held during reset are ignored.
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
        #2 arst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("midrst_q_on", 32'(q_s[1]), 32'h0);
        chk("midrst_usedw", 32'(usedw_s[0]), 32'h0);
        wrreq_i = 1'b1;
        data_i  = 8'h33;
        @(posedge clk_i);
        #1;
        compare_all();
        arst_i = 1'b0;
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        chk("post_rst_first_write", 32'(usedw_s[0]), 32'h1);

        // Randomised traffic with phases biased toward full, empty and balanced.
        pulse_reset();
        for (int p = 0; p < 6; p++) begin
            pw = (p % 3 == 0) ? 75 : (p % 3 == 1) ? 25 : 50;
            pr = 100 - pw;
            for (int c = 0; c < 400; c++) begin
                cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
